// File: rtl/msx_slot_responder.sv
// MSX cartridge slot responder.
// Synchronizes the host bus strobes, detects one memory or IO access per host
// cycle, forwards it as a single valid/ready request to the internal device
// bus, returns read data toward the host and stretches the host cycle with
// /WAIT while the internal side has not answered.
module msx_slot_responder #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter bit IO_ENABLE      = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        slot_sltsl_n,
   input  logic        slot_merq_n,
   input  logic        slot_iorq_n,
   input  logic        slot_rd_n,
   input  logic        slot_wr_n,
   input  logic [15:0] slot_a,
   input  logic [7:0]  slot_d_in,
   output logic [7:0]  slot_d_out,
   output logic        slot_d_dir,
   output logic        slot_wait,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_memory,
   output logic        bus_write,
   output logic [15:0] bus_address,
   output logic [7:0]  bus_wdata,
   input  logic [7:0]  bus_rdata
);

   // Last counter value inside REQ; the request is held for exactly
   // TIMEOUT_CYCLES clocks before being abandoned.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DRIVE,
      S_END
   } state_t;

   state_t      state;

   // Strobe order inside the synchronizer: {sltsl, merq, iorq, rd, wr}
   logic [4:0]  strb_p0;
   logic [4:0]  strb_p1;

   logic        sltsl_s;
   logic        merq_s;
   logic        iorq_s;
   logic        rd_s;
   logic        wr_s;

   logic        mem_rd;
   logic        mem_wr;
   logic        io_rd;
   logic        io_wr;
   logic        conflict;
   logic        access;
   logic        access_prev;
   logic        start;

   logic [7:0]  tmo_cnt;
   logic        released;
   logic        released_now;
   logic        handshake;
   logic        timed_out;

   // Two-flop synchronizer for the asynchronous host strobes. It carries no
   // reset so that it keeps tracking the pins while reset is held; this lets
   // access_prev see a strobe that is already active when reset releases.
   always_ff @(posedge clk) begin
      strb_p0 <= {slot_sltsl_n, slot_merq_n, slot_iorq_n, slot_rd_n, slot_wr_n};
      strb_p1 <= strb_p0;
   end

   assign sltsl_s = strb_p1[4];
   assign merq_s  = strb_p1[3];
   assign iorq_s  = strb_p1[2];
   assign rd_s    = strb_p1[1];
   assign wr_s    = strb_p1[0];

   // Access decode on the synchronized strobes; contradictory strobe
   // combinations are treated as no access at all.
   always_comb begin
      mem_rd   = ~sltsl_s & ~merq_s & ~rd_s & wr_s;
      mem_wr   = ~sltsl_s & ~merq_s & ~wr_s & rd_s;
      io_rd    = ~iorq_s & ~rd_s & wr_s & IO_ENABLE;
      io_wr    = ~iorq_s & ~wr_s & rd_s & IO_ENABLE;
      conflict = (~rd_s & ~wr_s) | (~merq_s & ~iorq_s);
      access   = ~conflict & (mem_rd | mem_wr | io_rd | io_wr);
      start    = access & ~access_prev;
   end

   // REQ-state decisions: a strobe released at any point during REQ means the
   // host no longer waits for data, so nothing is driven afterwards.
   always_comb begin
      released_now = released | ~access;
      handshake    = bus_valid & bus_ready;
      timed_out    = ~handshake & (tmo_cnt == TMO_LAST);
   end

   // Edge history of the decoded access; reset to 1 so a strobe held active
   // across reset release does not start a request.
   always_ff @(posedge clk) begin
      if (reset) begin
         access_prev <= 1'b1;
      end else begin
         access_prev <= access;
      end
   end

   // Main control FSM with registered bus and slot outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         slot_d_out  <= 8'hFF;
         slot_d_dir  <= 1'b0;
         slot_wait   <= 1'b0;
         bus_valid   <= 1'b0;
         bus_memory  <= 1'b0;
         bus_write   <= 1'b0;
         bus_address <= 16'h0000;
         bus_wdata   <= 8'h00;
         tmo_cnt     <= 8'h00;
         released    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (mem_rd | mem_wr) begin
                     bus_address <= slot_a;
                  end else begin
                     bus_address <= {8'h00, slot_a[7:0]};
                  end
                  bus_wdata  <= slot_d_in;
                  bus_memory <= mem_rd | mem_wr;
                  bus_write  <= mem_wr | io_wr;
                  bus_valid  <= 1'b1;
                  tmo_cnt    <= 8'h00;
                  released   <= 1'b0;
                  state      <= S_REQ;
               end
            end

            S_REQ: begin
               released <= released_now;
               if (handshake) begin
                  bus_valid <= 1'b0;
                  slot_wait <= 1'b0;
                  if (bus_write | released_now) begin
                     state <= S_END;
                  end else begin
                     slot_d_out <= bus_rdata;
                     slot_d_dir <= 1'b1;
                     state      <= S_DRIVE;
                  end
               end else if (timed_out) begin
                  // Abandoned access: a waiting read still gets an
                  // open-bus value so the host cycle can complete.
                  bus_valid <= 1'b0;
                  slot_wait <= 1'b0;
                  if (bus_write | released_now) begin
                     state <= S_END;
                  end else begin
                     slot_d_out <= 8'hFF;
                     slot_d_dir <= 1'b1;
                     state      <= S_DRIVE;
                  end
               end else begin
                  tmo_cnt   <= tmo_cnt + 8'd1;
                  slot_wait <= 1'b1;
               end
            end

            S_DRIVE: begin
               if (rd_s) begin
                  slot_d_dir <= 1'b0;
                  state      <= S_END;
               end
            end

            S_END: begin
               if (!access) begin
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msx_slot_responder.sv
// Bench for msx_slot_responder: directed host cycles, with expected bus
// requests and expected driven read data queued at stimulus time and checked
// by an independent monitor.
module tb_msx_slot_responder;

   logic        clk;
   logic        reset;
   logic        sltsl_n, merq_n, iorq_n, rd_n, wr_n;
   logic [15:0] a;
   logic [7:0]  d_in;
   logic        bus_ready;
   logic [7:0]  bus_rdata;

   logic [7:0]  slot_d_out;
   logic        slot_d_dir;
   logic        slot_wait;
   logic        bus_valid;
   logic        bus_memory;
   logic        bus_write;
   logic [15:0] bus_address;
   logic [7:0]  bus_wdata;

   logic [7:0]  n_d_out;
   logic        n_d_dir;
   logic        n_wait;
   logic        n_valid;
   logic        n_memory;
   logic        n_write;
   logic [15:0] n_address;
   logic [7:0]  n_wdata;

   typedef struct packed {
      logic        mem;
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } req_t;

   req_t        req_q[$];
   logic [7:0]  drv_q[$];

   int          vectors = 0;
   int          miscompares = 0;
   int          req_seen = 0;
   int          noio_seen = 0;
   int          wait_cycles = 0;
   int          vlen = 0;
   int          last_vlen = 0;
   bit          stable_ok;
   logic        vld_prev = 1'b0;
   logic        dir_prev = 1'b0;
   logic        n_prev = 1'b0;
   req_t        cap;

   msx_slot_responder #(.TIMEOUT_CYCLES(16), .IO_ENABLE(1'b1)) u_dut (
      .clk(clk), .reset(reset),
      .slot_sltsl_n(sltsl_n), .slot_merq_n(merq_n), .slot_iorq_n(iorq_n),
      .slot_rd_n(rd_n), .slot_wr_n(wr_n), .slot_a(a), .slot_d_in(d_in),
      .slot_d_out(slot_d_out), .slot_d_dir(slot_d_dir), .slot_wait(slot_wait),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_memory(bus_memory),
      .bus_write(bus_write), .bus_address(bus_address), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata)
   );

   msx_slot_responder #(.TIMEOUT_CYCLES(16), .IO_ENABLE(1'b0)) u_noio (
      .clk(clk), .reset(reset),
      .slot_sltsl_n(sltsl_n), .slot_merq_n(merq_n), .slot_iorq_n(iorq_n),
      .slot_rd_n(rd_n), .slot_wr_n(wr_n), .slot_a(a), .slot_d_in(d_in),
      .slot_d_out(n_d_out), .slot_d_dir(n_d_dir), .slot_wait(n_wait),
      .bus_valid(n_valid), .bus_ready(bus_ready), .bus_memory(n_memory),
      .bus_write(n_write), .bus_address(n_address), .bus_wdata(n_wdata),
      .bus_rdata(bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic exp_req(input logic mem, input logic wr, input logic [15:0] addr,
                          input logic [7:0] wd);
      req_t r;
      r.mem   = mem;
      r.wr    = wr;
      r.addr  = addr;
      r.wdata = wd;
      req_q.push_back(r);
   endtask

   task automatic release_all();
      sltsl_n = 1'b1; merq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
   endtask

   // Monitor: checks each new request against the queue, field stability while
   // valid, driven read data on each rising drive-direction edge.
   always @(negedge clk) begin
      if (bus_valid && !vld_prev) begin
         req_seen++;
         cap       = {bus_memory, bus_write, bus_address, bus_wdata};
         vlen      = 1;
         stable_ok = 1'b1;
         if (req_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_req: got request addr %0h with none expected", bus_address);
         end else begin
            req_t e;
            e = req_q.pop_front();
            check("req_memory", {31'd0, bus_memory}, {31'd0, e.mem});
            check("req_write", {31'd0, bus_write}, {31'd0, e.wr});
            check("req_address", {16'd0, bus_address}, {16'd0, e.addr});
            if (e.wr) check("req_wdata", {24'd0, bus_wdata}, {24'd0, e.wdata});
         end
      end else if (bus_valid) begin
         vlen++;
         if ({bus_memory, bus_write, bus_address, bus_wdata} !== cap) stable_ok = 1'b0;
      end else if (vld_prev) begin
         last_vlen = vlen;
         check("req_stable", {31'd0, stable_ok}, 32'd1);
      end
      vld_prev = bus_valid;

      if (slot_d_dir && !dir_prev) begin
         if (drv_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_drive: got data %0h driven with none expected", slot_d_out);
         end else begin
            check("drive_data", {24'd0, slot_d_out}, {24'd0, drv_q.pop_front()});
         end
      end
      dir_prev = slot_d_dir;

      if (slot_wait) wait_cycles++;
      if (n_valid && !n_prev) noio_seen++;
      n_prev = n_valid;
   end

   initial begin
      int rs, ns, ws;
      bit ok;
      reset = 1'b1;
      release_all();
      a = 16'h0000; d_in = 8'h00; bus_ready = 1'b0; bus_rdata = 8'h00;
      tick(5);
      @(negedge clk);
      check("rst_d_out", {24'd0, slot_d_out}, 32'hFF);
      check("rst_d_dir", {31'd0, slot_d_dir}, 32'd0);
      check("rst_wait", {31'd0, slot_wait}, 32'd0);
      check("rst_valid", {31'd0, bus_valid}, 32'd0);
      check("rst_memory", {31'd0, bus_memory}, 32'd0);
      check("rst_write", {31'd0, bus_write}, 32'd0);
      check("rst_address", {16'd0, bus_address}, 32'd0);
      check("rst_wdata", {24'd0, bus_wdata}, 32'd0);
      tick(1);
      reset = 1'b0;
      tick(3);

      // Memory read, fast internal side
      rs = req_seen; ns = noio_seen; ws = wait_cycles;
      bus_ready = 1'b1; bus_rdata = 8'h41; a = 16'h4000;
      exp_req(1'b1, 1'b0, 16'h4000, 8'h00);
      drv_q.push_back(8'h41);
      sltsl_n = 1'b0; merq_n = 1'b0; rd_n = 1'b0;
      tick(10);
      check("mrd_dir_held", {31'd0, slot_d_dir}, 32'd1);
      check("mrd_d_out", {24'd0, slot_d_out}, 32'h41);
      rd_n = 1'b1;
      tick(5);
      check("mrd_dir_off", {31'd0, slot_d_dir}, 32'd0);
      release_all();
      tick(4);
      check("mrd_wait_never", wait_cycles - ws, 32'd0);
      check("mrd_req_count", req_seen - rs, 32'd1);
      check("mrd_noio_mem", noio_seen - ns, 32'd1);

      // Memory write
      rs = req_seen;
      a = 16'h6000; d_in = 8'h5A;
      exp_req(1'b1, 1'b1, 16'h6000, 8'h5A);
      sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
      tick(8);
      check("mwr_dir", {31'd0, slot_d_dir}, 32'd0);
      release_all();
      tick(4);
      check("mwr_req_count", req_seen - rs, 32'd1);

      // IO write and IO read; the IO-disabled instance must stay silent
      ns = noio_seen;
      a = 16'h55A0; d_in = 8'h12;
      exp_req(1'b0, 1'b1, 16'h00A0, 8'h12);
      iorq_n = 1'b0; wr_n = 1'b0;
      tick(8);
      release_all();
      tick(4);
      a = 16'h1298; bus_rdata = 8'h77;
      exp_req(1'b0, 1'b0, 16'h0098, 8'h00);
      drv_q.push_back(8'h77);
      iorq_n = 1'b0; rd_n = 1'b0;
      tick(8);
      rd_n = 1'b1;
      tick(4);
      release_all();
      tick(4);
      check("io_disabled_silent", noio_seen - ns, 32'd0);

      // Read with the internal side 10 clocks late
      rs = req_seen;
      bus_ready = 1'b0; bus_rdata = 8'h3C; a = 16'h8123;
      exp_req(1'b1, 1'b0, 16'h8123, 8'h00);
      drv_q.push_back(8'h3C);
      sltsl_n = 1'b0; merq_n = 1'b0; rd_n = 1'b0;
      ok = 1'b0;
      ws = wait_cycles;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_valid) begin ok = 1'b1; break; end
      end
      check("slow_valid_seen", {31'd0, ok}, 32'd1);
      repeat (10) @(posedge clk);
      #1 bus_ready = 1'b1;
      tick(3);
      bus_ready = 1'b0;
      check("slow_wait_cycles", wait_cycles - ws, 32'd10);
      check("slow_wait_low", {31'd0, slot_wait}, 32'd0);
      check("slow_dir", {31'd0, slot_d_dir}, 32'd1);
      rd_n = 1'b1;
      tick(4);
      release_all();
      tick(4);
      check("slow_req_count", req_seen - rs, 32'd1);

      // Timeout after 16 clocks with no ready
      a = 16'hBFFF; bus_rdata = 8'h00;
      exp_req(1'b1, 1'b0, 16'hBFFF, 8'h00);
      drv_q.push_back(8'hFF);
      sltsl_n = 1'b0; merq_n = 1'b0; rd_n = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_valid) begin ok = 1'b1; break; end
      end
      check("tmo_valid_seen", {31'd0, ok}, 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!bus_valid) begin ok = 1'b1; break; end
      end
      check("tmo_valid_dropped", {31'd0, ok}, 32'd1);
      tick(1);
      check("tmo_valid_len", last_vlen, 32'd16);
      check("tmo_wait_low", {31'd0, slot_wait}, 32'd0);
      check("tmo_d_out", {24'd0, slot_d_out}, 32'hFF);
      check("tmo_dir", {31'd0, slot_d_dir}, 32'd1);
      rd_n = 1'b1;
      tick(4);
      release_all();
      tick(4);

      // rd released and reasserted while the request is pending
      rs = req_seen;
      a = 16'h4444; bus_rdata = 8'h99;
      exp_req(1'b1, 1'b0, 16'h4444, 8'h00);
      sltsl_n = 1'b0; merq_n = 1'b0; rd_n = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_valid) begin ok = 1'b1; break; end
      end
      check("rel_valid_seen", {31'd0, ok}, 32'd1);
      tick(1);
      rd_n = 1'b1;
      tick(3);
      rd_n = 1'b0;
      tick(4);
      check("rel_valid_held", {31'd0, bus_valid}, 32'd1);
      bus_ready = 1'b1;
      tick(3);
      bus_ready = 1'b0;
      check("rel_valid_done", {31'd0, bus_valid}, 32'd0);
      tick(4);
      check("rel_no_drive", {31'd0, slot_d_dir}, 32'd0);
      check("rel_req_count", req_seen - rs, 32'd1);
      rd_n = 1'b1;
      tick(4);
      release_all();
      tick(4);

      // Reset while driving read data, rd still low after release
      rs = req_seen;
      bus_ready = 1'b1; bus_rdata = 8'h5C; a = 16'h4001;
      exp_req(1'b1, 1'b0, 16'h4001, 8'h00);
      drv_q.push_back(8'h5C);
      sltsl_n = 1'b0; merq_n = 1'b0; rd_n = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (slot_d_dir) begin ok = 1'b1; break; end
      end
      check("rstd_drive_seen", {31'd0, ok}, 32'd1);
      tick(1);
      reset = 1'b1;
      tick(2);
      check("rstd_dir", {31'd0, slot_d_dir}, 32'd0);
      check("rstd_d_out", {24'd0, slot_d_out}, 32'hFF);
      reset = 1'b0;
      tick(8);
      check("rstd_no_restart", req_seen - rs, 32'd1);
      rd_n = 1'b1;
      exp_req(1'b1, 1'b0, 16'h4001, 8'h00);
      drv_q.push_back(8'h5C);
      tick(4);
      rd_n = 1'b0;
      tick(8);
      check("rstd_new_dir", {31'd0, slot_d_dir}, 32'd1);
      check("rstd_new_req", req_seen - rs, 32'd2);
      rd_n = 1'b1;
      tick(4);
      release_all();
      tick(4);

      // Contradictory strobe combinations
      rs = req_seen;
      sltsl_n = 1'b0; merq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
      tick(10);
      release_all();
      tick(4);
      check("rdwr_no_req", req_seen - rs, 32'd0);
      sltsl_n = 1'b0; merq_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0;
      tick(10);
      release_all();
      tick(4);
      check("merq_iorq_no_req", req_seen - rs, 32'd0);
      bus_ready = 1'b0;

      check("req_queue_empty", req_q.size(), 32'd0);
      check("drive_queue_empty", drv_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
